botao_emissor: RTL and testbench
================================

BOTAO_EMISSOR -- requirements
Module: botao_emissor

Interface
REQ-001 Parameter HOLD_CYCLES, default 4: cycles press is held high per emulated press (legal 1..255).
REQ-002 Parameter GAP_CYCLES, default 2: cycles press is held low after each press (legal 1..255).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 req  input  1  start request, sampled on rising edge of clk.
REQ-006 count  input  4  number of presses to emit, latched with accepted req.
REQ-007 press  output  1  emulated button line, registered, feeds a botao press input.
REQ-008 busy  output  1  high while a sequence is in progress.
REQ-009 done  output  1  one-cycle pulse when a sequence completes.

Function
REQ-010 FSM states: IDLE, BOUNCE (BOUNCE_EN only), HOLD, GAP, FIN.
REQ-011 IDLE: press=0, busy=0; req=1 accepted only here; req in any other state ignored, no queuing.
REQ-012 Accepted req with count=0: next state FIN, no press emitted.
REQ-013 Accepted req with count!=0: latch count into remaining counter; next state HOLD, or BOUNCE if BOUNCE_EN.
REQ-014 press, busy rise in the cycle after the accepting edge (1-cycle latency, registered).
REQ-015 HOLD: press=1 for exactly HOLD_CYCLES cycles, then GAP; remaining decremented on HOLD->GAP.
REQ-016 GAP: press=0 for exactly GAP_CYCLES cycles; then HOLD/BOUNCE if remaining!=0, else FIN.
REQ-017 FIN: single cycle, done=1, busy=0, press=0; always returns to IDLE; new req earliest one cycle after done.
REQ-018 busy=1 in BOUNCE, HOLD, GAP; 0 in IDLE, FIN.
REQ-019 Total sequence length for count=N (no BOUNCE_EN): N*(HOLD_CYCLES+GAP_CYCLES) busy cycles plus 1 FIN cycle.
REQ-020 Phase counter 8 bits, remaining counter 4 bits; no wrap-around reachable for legal parameters.
REQ-021 count changes after acceptance have no effect on the running sequence.
REQ-022 press never glitches: driven only from a flop, never from combinational logic.

Reset
REQ-023 rst_n=0 forces asynchronously: state IDLE, press=0, busy=0, done=0, counters 0.
REQ-024 Reset mid-sequence aborts it; no done pulse is produced for the aborted sequence.
REQ-025 After rst_n deassertion, block is in IDLE and accepts req on the first rising edge.

Configuration
REQ-026 Macro BOTAO_EMISSOR_BOUNCE_EN selects contact-bounce emulation.
REQ-027 Macro defined: each press starts with 4-cycle BOUNCE state driving press = 1,0,1,0, then HOLD; press phase lasts HOLD_CYCLES+4.
REQ-028 Macro undefined: BOUNCE state and its logic absent; presses are clean HOLD_CYCLES pulses.

Verification
REQ-029 Defaults, no macro, req=1 count=1 one cycle -> press high cycles 1-4 after accept, low 5-6, done at cycle 7, busy high cycles 1-6.
REQ-030 count=3 -> exactly 3 press pulses of 4 high/2 low, done once 19 cycles after accept; connected botao detect toggles 3 times.
REQ-031 count=0 -> press never rises, busy stays 0, done pulses the cycle after accept.
REQ-032 req reasserted with count=5 during busy of a count=2 sequence -> ignored, exactly 2 pulses, single done.
REQ-033 rst_n low during second HOLD of count=3 -> press, busy fall immediately (asynchronously), no done; fresh req after release works normally.
REQ-034 BOTAO_EMISSOR_BOUNCE_EN defined, count=1 -> press pattern 1,0,1,0,1,1,1,1,0,0, then done.

Source files
------------

// File: rtl/botao_emissor.sv
// botao_emissor: emits a burst of emulated button presses on a registered line.
// An accepted request latches how many presses to emit. Each press is held
// high for HOLD_CYCLES cycles and then low for GAP_CYCLES cycles. A one-cycle
// done pulse marks the end of the burst.
// Optional feature: define BOTAO_EMISSOR_BOUNCE_EN to add contact-bounce
// emulation. With it, every press starts with a 4-cycle 1,0,1,0 pattern.
module botao_emissor #(
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req,
    input  logic [3:0] count,
    output logic       press,
    output logic       busy,
    output logic       done
);

`ifdef BOTAO_EMISSOR_BOUNCE_EN
    typedef enum logic [2:0] {IDLE, BOUNCE, HOLD, GAP, FIN} state_t;
    localparam state_t     PRESS_START = BOUNCE;
    localparam logic [7:0] BOUNCE_LAST = 8'd3;
`else
    typedef enum logic [2:0] {IDLE, HOLD, GAP, FIN} state_t;
    localparam state_t     PRESS_START = HOLD;
`endif

    localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);
    localparam logic [7:0] GAP_LAST  = 8'(GAP_CYCLES - 1);

    state_t     state, state_nx;
    logic [7:0] phase, phase_nx;
    logic [3:0] remaining, remaining_nx;
    logic       press_nx, busy_nx, done_nx;

    // State register: FSM state, phase counter and remaining-press counter.
    // NOTE: sequential state uses non-blocking assignments so that every flop
    // samples the pre-edge values, whatever order the blocks are evaluated in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            phase     <= '0;
            remaining <= '0;
        end else begin
            state     <= state_nx;
            phase     <= phase_nx;
            remaining <= remaining_nx;
        end
    end

    // Next-state logic: phase counting inside each state and the press sequencing.
    // NOTE: every signal gets a default before the case statement. Without it,
    // any path that leaves a signal unassigned would infer a latch.
    always_comb begin
        state_nx     = state;
        phase_nx     = phase;
        remaining_nx = remaining;
        case (state)
            IDLE: begin
                // The request is only accepted here. Other states ignore it.
                if (req) begin
                    phase_nx = '0;
                    if (count == 4'd0) begin
                        state_nx = FIN;
                    end else begin
                        remaining_nx = count;
                        state_nx     = PRESS_START;
                    end
                end
            end
`ifdef BOTAO_EMISSOR_BOUNCE_EN
            BOUNCE: begin
                if (phase == BOUNCE_LAST) begin
                    state_nx = HOLD;
                    phase_nx = '0;
                end else begin
                    phase_nx = phase + 8'd1;
                end
            end
`endif
            HOLD: begin
                if (phase == HOLD_LAST) begin
                    state_nx     = GAP;
                    phase_nx     = '0;
                    remaining_nx = remaining - 4'd1;
                end else begin
                    phase_nx = phase + 8'd1;
                end
            end
            GAP: begin
                if (phase == GAP_LAST) begin
                    phase_nx = '0;
                    state_nx = (remaining != 4'd0) ? PRESS_START : FIN;
                end else begin
                    phase_nx = phase + 8'd1;
                end
            end
            FIN: begin
                state_nx = IDLE;
                phase_nx = '0;
            end
            default: begin
                state_nx = IDLE;
                phase_nx = '0;
            end
        endcase
    end

    // Output decode: outputs are derived from the upcoming state so that the
    // registered outputs line up with the state they describe.
    always_comb begin
        press_nx = (state_nx == HOLD);
`ifdef BOTAO_EMISSOR_BOUNCE_EN
        // Bounce drives press high on even phases: 1,0,1,0.
        if (state_nx == BOUNCE) press_nx = ~phase_nx[0];
        busy_nx = (state_nx == BOUNCE) || (state_nx == HOLD) || (state_nx == GAP);
`else
        busy_nx = (state_nx == HOLD) || (state_nx == GAP);
`endif
        done_nx = (state_nx == FIN);
    end

    // Output register: press comes straight from a flop, so it never glitches.
    // NOTE: these are control flops, so the asynchronous reset clears all of
    // them. An aborted burst therefore drops press and busy at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            press <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            press <= press_nx;
            busy  <= busy_nx;
            done  <= done_nx;
        end
    end

endmodule

// File: tb/tb_botao_emissor.sv
// tb_botao_emissor: directed bench for botao_emissor.
// A behavioural model builds each burst as a queue of output triples. The
// triples are checked every cycle. Literal traces pin the model itself.
// The bench follows BOTAO_EMISSOR_BOUNCE_EN when that macro is defined.
module tb_botao_emissor;

    localparam int HC = 4;
    localparam int GC = 2;
`ifdef BOTAO_EMISSOR_BOUNCE_EN
    localparam int BL = 4;
`else
    localparam int BL = 0;
`endif
    localparam int SEQ       = BL + HC + GC;         // cycles per press incl. gap
    localparam int RISES_PER = (BL != 0) ? 3 : 1;     // rising edges per press
    localparam int RST_CYC   = SEQ + BL + 2;          // inside the second HOLD

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req;
    logic [3:0] count;
    logic       press, busy, done;

    int n_checks = 0;
    int n_fail   = 0;

    botao_emissor #(.HOLD_CYCLES(HC), .GAP_CYCLES(GC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .count (count),
        .press (press),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: the expected {press,busy,done} for every cycle of a burst.
    logic [2:0] exp_out = 3'b000;
    logic [2:0] q[$];

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                q.delete();
                exp_out = 3'b000;
            end else begin
                if (exp_out == 3'b000 && req === 1'b1) begin
                    for (int p = 0; p < int'(count); p++) begin
                        for (int b = 0; b < BL; b++) q.push_back((b % 2 == 0) ? 3'b110 : 3'b010);
                        for (int h = 0; h < HC; h++) q.push_back(3'b110);
                        for (int g = 0; g < GC; g++) q.push_back(3'b010);
                    end
                    q.push_back(3'b001);
                end
                exp_out = (q.size() != 0) ? q.pop_front() : 3'b000;
            end
        end
    end

    // Cycle-by-cycle comparison against the model.
    initial begin
        forever begin
            @(negedge clk);
            check("cycle_outputs", 32'({press, busy, done}), 32'(exp_out));
        end
    end

    // Drive an accepted request. Returns at the sample point of cycle 1.
    task automatic start(input logic [3:0] n);
        @(negedge clk);
        req   = 1'b1;
        count = n;
        @(negedge clk);
        req   = 1'b0;
        count = ~n;    // later count changes must not matter
    endtask

    // Observe a burst from cycle 1 until done (or until the budget runs out).
    task automatic watch(input int budget, input int inject_at,
                         output int rises, output int done_cyc,
                         output logic [31:0] ptrace, output logic [31:0] btrace,
                         output logic busy_seen);
        logic prev = 1'b0;
        rises = 0; done_cyc = 0; ptrace = '0; btrace = '0; busy_seen = 1'b0;
        for (int c = 1; c <= budget; c++) begin
            if (c <= 32) begin
                ptrace[c-1] = press;
                btrace[c-1] = busy;
            end
            if (press && !prev) rises++;
            prev      = press;
            busy_seen = busy_seen | busy;
            if (c == inject_at) begin
                req   = 1'b1;
                count = 4'd5;
            end
            if (c == inject_at + 2) req = 1'b0;
            if (done) begin
                done_cyc = c;
                break;
            end
            @(negedge clk);
        end
        if (done_cyc == 0) check("watch_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    int          rises, done_cyc;
    logic [31:0] pt, bt;
    logic        bseen;

    initial begin
        rst_n = 1'b0;
        req   = 1'b0;
        count = 4'd0;
        repeat (2) @(negedge clk);
        check("reset_outputs", 32'({press, busy, done}), 32'd0);
        rst_n = 1'b1;

        // Single press: literal trace.
        start(4'd1);
        watch(100, 0, rises, done_cyc, pt, bt, bseen);
`ifdef BOTAO_EMISSOR_BOUNCE_EN
        check("c1_press_trace", pt & 32'h7FF, 32'b00011110101);
        check("c1_busy_trace",  bt & 32'h7FF, 32'b01111111111);
        check("c1_done_cycle",  32'(done_cyc), 32'd11);
`else
        check("c1_press_trace", pt & 32'h7F, 32'b0001111);
        check("c1_busy_trace",  bt & 32'h7F, 32'b0111111);
        check("c1_done_cycle",  32'(done_cyc), 32'd7);
`endif

        // Three presses.
        start(4'd3);
        watch(200, 0, rises, done_cyc, pt, bt, bseen);
        check("c3_rises",      32'(rises), 32'(3 * RISES_PER));
        check("c3_done_cycle", 32'(done_cyc), 32'(3 * SEQ + 1));

        // Zero presses: done on cycle 1 with no activity.
        start(4'd0);
        watch(10, 0, rises, done_cyc, pt, bt, bseen);
        check("c0_rises",      32'(rises), 32'd0);
        check("c0_busy_seen",  32'(bseen), 32'd0);
        check("c0_done_cycle", 32'(done_cyc), 32'd1);
        // A request raised during the FIN cycle is ignored.
        req   = 1'b1;
        count = 4'd1;
        @(negedge clk);
        req = 1'b0;
        check("fin_req_ignored", 32'({press, busy}), 32'd0);

        // A re-request while busy is ignored.
        start(4'd2);
        watch(200, 3, rises, done_cyc, pt, bt, bseen);
        check("busy_req_rises", 32'(rises), 32'(2 * RISES_PER));
        check("busy_req_done",  32'(done_cyc), 32'(2 * SEQ + 1));
        @(negedge clk);
        check("busy_req_idle_after", 32'({press, busy, done}), 32'd0);

        // Reset in the middle of the second HOLD.
        start(4'd3);
        for (int c = 1; c < RST_CYC; c++) @(negedge clk);
        check("pre_reset_active", 32'({press, busy}), 32'b11);
        #2 rst_n = 1'b0;
        #1 check("async_reset_drop", 32'({press, busy, done}), 32'd0);
        repeat (3) @(negedge clk);
        check("no_done_after_abort", 32'(done), 32'd0);
        // Release the reset and request in the same cycle: the first edge accepts.
        rst_n = 1'b1;
        req   = 1'b1;
        count = 4'd2;
        @(negedge clk);
        req   = 1'b0;
        count = 4'd9;
        watch(200, 0, rises, done_cyc, pt, bt, bseen);
        check("post_reset_rises", 32'(rises), 32'(2 * RISES_PER));
        check("post_reset_done",  32'(done_cyc), 32'(2 * SEQ + 1));

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
